i2c_reg_ctrl: RTL and testbench
===============================

# i2c_reg_ctrl

Register-level transaction sequencer for the I2C bit-shift engine. It accepts single-byte register write/read requests (7-bit device ID, 8- or 16-bit register address) from a host, such as a sensor-init ROM walker or a UART command decoder. It breaks each request into byte commands on the engine's Cmd/Go/Trans_Done handshake. It returns read data, ACK-error and timeout status.

## Interface

Parameters:
- TIMEOUT_CYC, 20'd1_000_000: maximum Clk cycles to wait for Trans_Done per byte before aborting.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  one-cycle pulse, start register write.
- rd_req  input  1  one-cycle pulse, start register read.
- dev_id  input  7  7-bit slave address.
- addr_mode  input  1  1 = 16-bit register address, 0 = 8-bit.
- reg_addr  input  16  register address; only [7:0] is used when addr_mode=0.
- wr_data  input  8  write byte.
- rd_data  output  8  last read byte.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle pulse at transaction end.
- ack_err  output  1  at least one slave NACK in the last transaction; valid with done.
- timeout  output  1  last transaction aborted by the watchdog; valid with done.
- Cmd  output  6  engine command, one-hot OR: WR=0x01, STA=0x02, RD=0x04, STO=0x08, ACK=0x10, NACK=0x20.
- Go  output  1  one-cycle engine start pulse.
- Tx_DATA  output  8  engine write byte.
- Rx_DATA  input  8  engine read byte.
- Trans_Done  input  1  engine one-cycle completion pulse.
- ack_o  input  1  engine sampled ACK bit (0 = ACK); valid when Trans_Done is high.

## Operation

- Requests are latched (dev_id, addr_mode, reg_addr, wr_data) only in IDLE. Requests arriving while busy are ignored.
- If wr_req and rd_req are high in the same cycle, write wins.
- Write sequence: WR_DEV {STA|WR, dev_id,0}. Then WR_AH {WR, addr[15:8]}, only when addr_mode=1. Then WR_AL {WR, addr[7:0]}. Then WR_DAT {WR|STO, wr_data}.
- Read sequence: WR_DEV, optional WR_AH, WR_AL. Then RD_DEVR {STA|WR, dev_id,1}, a repeated start. Then RD_DAT {RD|NACK|STO}. On its Trans_Done, capture rd_data <= Rx_DATA.
- Each step state has two phases: ISSUE, where Cmd/Tx_DATA are driven and Go is pulsed for one cycle, then WAIT for Trans_Done.
- Cmd/Tx_DATA stay stable from the Go cycle until Trans_Done, because the engine reads Cmd throughout the byte.
- NACK handling: ack_o=1 on a write-byte Trans_Done sets sticky ack_err. The sequence still runs to completion so the bus always ends with a STOP; the engine has no standalone STOP command. ack_o is ignored on RD_DAT.
- Watchdog: the counter clears at each Go and increments in WAIT. When it reaches TIMEOUT_CYC-1: timeout=1, Go stays low, and the block goes to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. ack_err and timeout clear when the next request is accepted.
- States: IDLE, WR_DEV, WR_AH, WR_AL, WR_DAT, RD_DEVR, RD_DAT, DONE.

## Timing

- Reset values: rd_data=0, busy=0, done=0, ack_err=0, timeout=0, Cmd=0, Go=0, Tx_DATA=0; FSM in IDLE.
- Request accepted at cycle t: busy=1 and the first Go are at t+1.
- Trans_Done at cycle n: the next Go is at n+1. The engine is guaranteed to be in its idle state at n.
- Final Trans_Done at n: done=1 and busy=0 at n+1; rd_data is valid from n+1.
- A reset mid-transaction returns all outputs to reset values immediately. Go is never left high.
- A Trans_Done while not in WAIT is ignored.

## Structure

- Shared package/include `i2c_defs`: Cmd one-hot constants (WR, STA, RD, STO, ACK, NACK) and the state encoding. The bit-shift engine uses the same constants.
- No sub-module. A thin top `i2c_reg_top` instantiates this block together with the engine.

## Test plan

- **8-bit write.** Stimulus: wr_req, dev 0x3C, mode 0, addr 0x12, data 0xA5, slave model ACKs all bytes. Required response:
  - Cmd/Tx sequence {0x03,0x78}, {0x01,0x12}, {0x09,0xA5}.
  - done once; ack_err=0.
- **16-bit read.** Stimulus: rd_req, dev 0x3C, mode 1, addr 0x300A, slave returns 0x56. Required response:
  - Sequence {0x03,0x78}, {0x01,0x30}, {0x01,0x0A}, {0x03,0x79}, {0x2C}.
  - rd_data=0x56.
- **NACK.** Stimulus: slave NACKs the device byte of an 8-bit write. Required response: all 3 bytes are still issued, the last carries STO; done with ack_err=1.
- **Timeout.** Stimulus: engine model never returns Trans_Done, TIMEOUT_CYC=100. Required response: done exactly 100 cycles after Go; timeout=1; no further Go.
- **Simultaneous and busy requests.** Stimulus: wr_req and rd_req in the same cycle, then a second rd_req while busy. Required response: only the write executes; exactly one done.
- **Reset mid-transaction.** Stimulus: assert Rst_n low during WR_AL. Required response: all outputs at reset values; a new request afterwards starts at WR_DEV.

Source files
------------

// File: rtl/i2c_defs.sv
// Shared I2C definitions: engine command one-hot codes, sequencer state
// encoding and the per-step command/data/successor lookup helpers.
package i2c_defs;

  localparam logic [5:0] CMD_WR   = 6'h01;
  localparam logic [5:0] CMD_STA  = 6'h02;
  localparam logic [5:0] CMD_RD   = 6'h04;
  localparam logic [5:0] CMD_STO  = 6'h08;
  localparam logic [5:0] CMD_ACK  = 6'h10;
  localparam logic [5:0] CMD_NACK = 6'h20;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DEV  = 3'd1,
    WR_AH   = 3'd2,
    WR_AL   = 3'd3,
    WR_DAT  = 3'd4,
    RD_DEVR = 3'd5,
    RD_DAT  = 3'd6,
    DONE    = 3'd7
  } state_t;

  function automatic logic [5:0] step_cmd(input state_t st);
    case (st)
      WR_DEV, RD_DEVR: step_cmd = CMD_STA | CMD_WR;
      WR_AH, WR_AL:    step_cmd = CMD_WR;
      WR_DAT:          step_cmd = CMD_WR | CMD_STO;
      RD_DAT:          step_cmd = CMD_RD | CMD_NACK | CMD_STO;
      default:         step_cmd = 6'h00;
    endcase
  endfunction

  function automatic logic [7:0] step_tx(input state_t st, input logic [6:0] dev,
                                         input logic [15:0] addr, input logic [7:0] wdat);
    case (st)
      WR_DEV:  step_tx = {dev, 1'b0};
      WR_AH:   step_tx = addr[15:8];
      WR_AL:   step_tx = addr[7:0];
      WR_DAT:  step_tx = wdat;
      RD_DEVR: step_tx = {dev, 1'b1};
      default: step_tx = 8'h00;
    endcase
  endfunction

  function automatic state_t next_step(input state_t st, input logic mode16, input logic is_rd);
    case (st)
      WR_DEV:  next_step = mode16 ? WR_AH : WR_AL;
      WR_AH:   next_step = WR_AL;
      WR_AL:   next_step = is_rd ? RD_DEVR : WR_DAT;
      RD_DEVR: next_step = RD_DAT;
      default: next_step = DONE;
    endcase
  endfunction

  // Bytes the master transmits, whose slave ACK bit is meaningful.
  function automatic logic is_write_byte(input state_t st);
    case (st)
      WR_DEV, WR_AH, WR_AL, WR_DAT, RD_DEVR: is_write_byte = 1'b1;
      default:                               is_write_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Register-level I2C transaction sequencer: splits single-byte register
// writes/reads into engine byte commands, with NACK and watchdog status.
module i2c_reg_ctrl
  import i2c_defs::*;
#(
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [6:0]  dev_id,
  input  logic        addr_mode,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        timeout,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic [7:0]  Rx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o
);

  state_t      state_r, state_s, nxt_s;
  logic        is_rd_r, is_rd_s;
  logic [6:0]  dev_r, dev_s;
  logic        mode_r, mode_s;
  logic [15:0] addr_r, addr_s;
  logic [7:0]  wdat_r, wdat_s;
  logic [19:0] cnt_r, cnt_s;
  logic [7:0]  rd_data_r, rd_data_s;
  logic        busy_r, busy_s, done_r, done_s;
  logic        ack_err_r, ack_err_s, timeout_r, timeout_s;
  logic [5:0]  cmd_r, cmd_s;
  logic        go_r, go_s;
  logic [7:0]  tx_r, tx_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_s   = state_r;
    is_rd_s   = is_rd_r;
    dev_s     = dev_r;
    mode_s    = mode_r;
    addr_s    = addr_r;
    wdat_s    = wdat_r;
    cnt_s     = cnt_r;
    rd_data_s = rd_data_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    ack_err_s = ack_err_r;
    timeout_s = timeout_r;
    cmd_s     = cmd_r;
    go_s      = 1'b0;
    tx_s      = tx_r;
    nxt_s     = next_step(state_r, mode_r, is_rd_r);
    case (state_r)
      IDLE: begin
        if (wr_req || rd_req) begin
          state_s   = WR_DEV;
          is_rd_s   = ~wr_req;
          dev_s     = dev_id;
          mode_s    = addr_mode;
          addr_s    = reg_addr;
          wdat_s    = wr_data;
          ack_err_s = 1'b0;
          timeout_s = 1'b0;
          busy_s    = 1'b1;
          go_s      = 1'b1;
          cnt_s     = 20'd0;
          cmd_s     = step_cmd(WR_DEV);
          tx_s      = step_tx(WR_DEV, dev_id, reg_addr, wr_data);
        end else begin
          busy_s = 1'b0;
        end
      end
      WR_DEV, WR_AH, WR_AL, WR_DAT, RD_DEVR, RD_DAT: begin
        // The Go cycle is the issue phase; completion is only honoured afterwards.
        if (Trans_Done && !go_r) begin
          ack_err_s = ack_err_r | (is_write_byte(state_r) & ack_o);
          if (state_r == RD_DAT) begin
            rd_data_s = Rx_DATA;
          end else begin
            rd_data_s = rd_data_r;
          end
          if (nxt_s == DONE) begin
            state_s = DONE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            cmd_s   = 6'h00;
          end else begin
            state_s = nxt_s;
            go_s    = 1'b1;
            cnt_s   = 20'd0;
            cmd_s   = step_cmd(nxt_s);
            tx_s    = step_tx(nxt_s, dev_r, addr_r, wdat_r);
          end
        end else if (cnt_r == TIMEOUT_CYC - 20'd1) begin
          timeout_s = 1'b1;
          state_s   = DONE;
          done_s    = 1'b1;
          busy_s    = 1'b0;
          cmd_s     = 6'h00;
        end else begin
          cnt_s = cnt_r + 20'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= IDLE;
      is_rd_r   <= 1'b0;
      dev_r     <= 7'd0;
      mode_r    <= 1'b0;
      addr_r    <= 16'd0;
      wdat_r    <= 8'd0;
      cnt_r     <= 20'd0;
      rd_data_r <= 8'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      timeout_r <= 1'b0;
      cmd_r     <= 6'd0;
      go_r      <= 1'b0;
      tx_r      <= 8'd0;
    end else begin
      state_r   <= state_s;
      is_rd_r   <= is_rd_s;
      dev_r     <= dev_s;
      mode_r    <= mode_s;
      addr_r    <= addr_s;
      wdat_r    <= wdat_s;
      cnt_r     <= cnt_s;
      rd_data_r <= rd_data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      ack_err_r <= ack_err_s;
      timeout_r <= timeout_s;
      cmd_r     <= cmd_s;
      go_r      <= go_s;
      tx_r      <= tx_s;
    end
  end

  assign rd_data = rd_data_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign timeout = timeout_r;
  assign Cmd     = cmd_r;
  assign Go      = go_r;
  assign Tx_DATA = tx_r;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a simple byte-engine/slave model.
module tb_i2c_reg_ctrl;

  localparam logic [19:0] TMO = 20'd100;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [6:0]  dev_id = 7'd0;
  logic        addr_mode = 1'b0;
  logic [15:0] reg_addr = 16'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [7:0]  rd_data;
  logic        busy, done, ack_err, timeout, Go;
  logic [5:0]  Cmd;
  logic [7:0]  Tx_DATA;
  logic [7:0]  Rx_DATA = 8'd0;
  logic        Trans_Done = 1'b0;
  logic        ack_o = 1'b0;

  int cmp = 0;
  int mism = 0;

  // engine model state
  int         cyc = 0;
  int         nlog = 0, cur_idx = 0, dly = 0, nack_at = -1;
  int         done_cnt = 0, done_cyc = 0, stable_bad = 0;
  bit         pend = 1'b0, eng_en = 1'b1;
  logic [7:0] rx_val = 8'h00;
  logic [5:0] lc [64];
  logic [7:0] lt [64];
  int         lg [64];
  int         td [64];
  logic       last_ack_err = 1'b0, last_timeout = 1'b0, last_busy = 1'b0;

  i2c_reg_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .wr_req(wr_req), .rd_req(rd_req),
    .dev_id(dev_id), .addr_mode(addr_mode), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout),
    .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA),
    .Trans_Done(Trans_Done), .ack_o(ack_o)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Engine/slave model: logs every Go, answers after a few cycles, watches done.
  always @(negedge Clk) begin
    if (Trans_Done) Trans_Done = 1'b0;
    if (!Rst_n) begin
      pend = 1'b0;
    end else if (Go) begin
      if (nlog < 64) begin
        lc[nlog] = Cmd;
        lt[nlog] = Tx_DATA;
        lg[nlog] = cyc;
        cur_idx  = nlog;
        nlog++;
      end
      pend = eng_en;
      dly  = 3;
    end else if (pend) begin
      if (Cmd !== lc[cur_idx] || Tx_DATA !== lt[cur_idx]) stable_bad++;
      dly--;
      if (dly == 0) begin
        Trans_Done  = 1'b1;
        ack_o       = Cmd[2] ? 1'b1 : (cur_idx == nack_at);
        Rx_DATA     = rx_val;
        td[cur_idx] = cyc;
        pend        = 1'b0;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      last_ack_err = ack_err;
      last_timeout = timeout;
      last_busy    = busy;
    end
  end

  task automatic start(input logic w, input logic r, input logic [6:0] d, input logic m,
                       input logic [15:0] a, input logic [7:0] wd);
    @(negedge Clk);
    wr_req = w; rd_req = r; dev_id = d; addr_mode = m; reg_addr = a; wr_data = wd;
    @(negedge Clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (done_cnt != start_cnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    cmp++; if (rd_data !== 8'h00) begin mism++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    cmp++; if (busy !== 1'b0) begin mism++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    cmp++; if (done !== 1'b0) begin mism++; $display("FAIL reset_done: got %0b expected 0", done); end
    cmp++; if (ack_err !== 1'b0 || timeout !== 1'b0) begin mism++; $display("FAIL reset_status: got %0b%0b expected 00", ack_err, timeout); end
    cmp++; if (Cmd !== 6'h00 || Go !== 1'b0 || Tx_DATA !== 8'h00) begin mism++; $display("FAIL reset_engine_if: got cmd=%0h go=%0b tx=%0h expected 0/0/0", Cmd, Go, Tx_DATA); end
  endtask

  task automatic test_write_8;
    int b, dc; bit ok;
    b = nlog; dc = done_cnt;
    start(1'b1, 1'b0, 7'h3C, 1'b0, 16'h0012, 8'hA5);
    cmp++; if (busy !== 1'b1 || Go !== 1'b1) begin mism++; $display("FAIL wr8_accept: got busy=%0b go=%0b expected 1/1", busy, Go); end
    wait_done(dc, 200, ok);
    cmp++; if (!ok) begin mism++; $display("FAIL wr8_done_wait: got no done expected done"); end
    cmp++; if (nlog - b != 3) begin mism++; $display("FAIL wr8_nbytes: got %0d expected 3", nlog - b); end
    cmp++; if ({lc[b], lt[b]} !== {6'h03, 8'h78}) begin mism++; $display("FAIL wr8_byte0: got %0h/%0h expected 03/78", lc[b], lt[b]); end
    cmp++; if ({lc[b+1], lt[b+1]} !== {6'h01, 8'h12}) begin mism++; $display("FAIL wr8_byte1: got %0h/%0h expected 01/12", lc[b+1], lt[b+1]); end
    cmp++; if ({lc[b+2], lt[b+2]} !== {6'h09, 8'hA5}) begin mism++; $display("FAIL wr8_byte2: got %0h/%0h expected 09/a5", lc[b+2], lt[b+2]); end
    cmp++; if (last_ack_err !== 1'b0 || last_timeout !== 1'b0 || last_busy !== 1'b0) begin mism++; $display("FAIL wr8_status: got ack_err=%0b timeout=%0b busy=%0b expected 0/0/0", last_ack_err, last_timeout, last_busy); end
    cmp++; if (done_cyc - td[b+2] != 1) begin mism++; $display("FAIL wr8_done_latency: got %0d expected 1", done_cyc - td[b+2]); end
    cmp++; if (lg[b+1] - td[b] != 1) begin mism++; $display("FAIL wr8_go_latency: got %0d expected 1", lg[b+1] - td[b]); end
    repeat (5) @(negedge Clk);
    cmp++; if (done_cnt - dc != 1) begin mism++; $display("FAIL wr8_done_count: got %0d expected 1", done_cnt - dc); end
  endtask

  task automatic test_read_16;
    int b, dc; bit ok;
    b = nlog; dc = done_cnt; rx_val = 8'h56;
    start(1'b0, 1'b1, 7'h3C, 1'b1, 16'h300A, 8'h00);
    wait_done(dc, 300, ok);
    cmp++; if (!ok) begin mism++; $display("FAIL rd16_done_wait: got no done expected done"); end
    cmp++; if (nlog - b != 5) begin mism++; $display("FAIL rd16_nbytes: got %0d expected 5", nlog - b); end
    cmp++; if ({lc[b], lt[b]} !== {6'h03, 8'h78}) begin mism++; $display("FAIL rd16_byte0: got %0h/%0h expected 03/78", lc[b], lt[b]); end
    cmp++; if ({lc[b+1], lt[b+1]} !== {6'h01, 8'h30}) begin mism++; $display("FAIL rd16_byte1: got %0h/%0h expected 01/30", lc[b+1], lt[b+1]); end
    cmp++; if ({lc[b+2], lt[b+2]} !== {6'h01, 8'h0A}) begin mism++; $display("FAIL rd16_byte2: got %0h/%0h expected 01/0a", lc[b+2], lt[b+2]); end
    cmp++; if ({lc[b+3], lt[b+3]} !== {6'h03, 8'h79}) begin mism++; $display("FAIL rd16_byte3: got %0h/%0h expected 03/79", lc[b+3], lt[b+3]); end
    cmp++; if (lc[b+4] !== 6'h2C) begin mism++; $display("FAIL rd16_byte4: got %0h expected 2c", lc[b+4]); end
    cmp++; if (rd_data !== 8'h56) begin mism++; $display("FAIL rd16_data: got %0h expected 56", rd_data); end
    cmp++; if (last_ack_err !== 1'b0) begin mism++; $display("FAIL rd16_ack_err: got %0b expected 0", last_ack_err); end
    cmp++; if (stable_bad != 0) begin mism++; $display("FAIL cmd_stable: got %0d changes expected 0", stable_bad); end
    rx_val = 8'h00;
  endtask

  task automatic test_nack;
    int b, dc; bit ok;
    b = nlog; dc = done_cnt; nack_at = b;
    start(1'b1, 1'b0, 7'h3C, 1'b0, 16'h0012, 8'hA5);
    wait_done(dc, 200, ok);
    nack_at = -1;
    cmp++; if (!ok) begin mism++; $display("FAIL nack_done_wait: got no done expected done"); end
    cmp++; if (nlog - b != 3) begin mism++; $display("FAIL nack_nbytes: got %0d expected 3", nlog - b); end
    cmp++; if (lc[b+2] !== 6'h09) begin mism++; $display("FAIL nack_stop: got %0h expected 09", lc[b+2]); end
    cmp++; if (last_ack_err !== 1'b1 || last_timeout !== 1'b0) begin mism++; $display("FAIL nack_status: got ack_err=%0b timeout=%0b expected 1/0", last_ack_err, last_timeout); end
  endtask

  task automatic test_timeout;
    int b, dc; bit ok;
    b = nlog; dc = done_cnt; eng_en = 1'b0;
    start(1'b1, 1'b0, 7'h11, 1'b0, 16'h0001, 8'h22);
    wait_done(dc, 300, ok);
    cmp++; if (!ok) begin mism++; $display("FAIL tmo_done_wait: got no done expected done"); end
    cmp++; if (done_cyc - lg[b] != 100) begin mism++; $display("FAIL tmo_latency: got %0d expected 100", done_cyc - lg[b]); end
    cmp++; if (last_timeout !== 1'b1 || last_ack_err !== 1'b0) begin mism++; $display("FAIL tmo_status: got timeout=%0b ack_err=%0b expected 1/0", last_timeout, last_ack_err); end
    repeat (10) @(negedge Clk);
    cmp++; if (nlog - b != 1) begin mism++; $display("FAIL tmo_no_go: got %0d expected 1", nlog - b); end
    eng_en = 1'b1;
  endtask

  task automatic test_simul_busy;
    int b, dc; bit ok;
    b = nlog; dc = done_cnt;
    start(1'b1, 1'b1, 7'h50, 1'b0, 16'h0044, 8'h11);
    cmp++; if (timeout !== 1'b0 || ack_err !== 1'b0) begin mism++; $display("FAIL simul_clear: got timeout=%0b ack_err=%0b expected 0/0", timeout, ack_err); end
    repeat (2) @(negedge Clk);
    start(1'b0, 1'b1, 7'h33, 1'b1, 16'hBEEF, 8'h00);
    wait_done(dc, 200, ok);
    repeat (30) @(negedge Clk);
    cmp++; if (done_cnt - dc != 1) begin mism++; $display("FAIL simul_done_count: got %0d expected 1", done_cnt - dc); end
    cmp++; if (nlog - b != 3) begin mism++; $display("FAIL simul_nbytes: got %0d expected 3", nlog - b); end
    cmp++; if ({lc[b], lt[b]} !== {6'h03, 8'hA0}) begin mism++; $display("FAIL simul_byte0: got %0h/%0h expected 03/a0", lc[b], lt[b]); end
    cmp++; if ({lc[b+2], lt[b+2]} !== {6'h09, 8'h11}) begin mism++; $display("FAIL simul_byte2: got %0h/%0h expected 09/11", lc[b+2], lt[b+2]); end
  endtask

  task automatic test_reset_mid;
    int b, dc; bit ok;
    b = nlog;
    start(1'b1, 1'b0, 7'h21, 1'b1, 16'h1234, 8'h77);
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      #1;
      if (nlog - b >= 3) break;
    end
    cmp++; if (lc[b+2] !== 6'h01 || lt[b+2] !== 8'h34) begin mism++; $display("FAIL rstmid_reach_al: got %0h/%0h expected 01/34", lc[b+2], lt[b+2]); end
    #1 Rst_n = 1'b0;
    #1;
    cmp++; if (busy !== 1'b0 || done !== 1'b0 || Go !== 1'b0) begin mism++; $display("FAIL rstmid_ctrl: got busy=%0b done=%0b go=%0b expected 0/0/0", busy, done, Go); end
    cmp++; if (Cmd !== 6'h00 || Tx_DATA !== 8'h00 || rd_data !== 8'h00) begin mism++; $display("FAIL rstmid_data: got cmd=%0h tx=%0h rd=%0h expected 0/0/0", Cmd, Tx_DATA, rd_data); end
    @(negedge Clk);
    @(negedge Clk);
    #1 Rst_n = 1'b1;
    b = nlog; dc = done_cnt;
    start(1'b1, 1'b0, 7'h21, 1'b0, 16'h0005, 8'h66);
    wait_done(dc, 200, ok);
    cmp++; if (!ok) begin mism++; $display("FAIL rstmid_restart_done: got no done expected done"); end
    cmp++; if ({lc[b], lt[b]} !== {6'h03, 8'h42}) begin mism++; $display("FAIL rstmid_restart_byte0: got %0h/%0h expected 03/42", lc[b], lt[b]); end
    cmp++; if (nlog - b != 3 || lc[b+2] !== 6'h09) begin mism++; $display("FAIL rstmid_restart_seq: got n=%0d last=%0h expected 3/09", nlog - b, lc[b+2]); end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    test_reset();
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    test_reset();
    test_write_8();
    test_read_16();
    test_nack();
    test_timeout();
    test_simul_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
